// File: rtl/decomp_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decomp_fetch_queue: in-order instruction prefetch queue that feeds the    |
// | decompressor and drops in-flight responses after a branch.                |
// | Optional FETCHQ_BYPASS_EN: forward a response straight to the head when   |
// | the queue is empty.                                                       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module decomp_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        pop,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        encode
);

  localparam int unsigned c_AW = $clog2(DEPTH);
  localparam int unsigned c_CW = $clog2(DEPTH + 1);
  localparam int unsigned c_OW = $clog2(MAX_OUT + 1);

  logic [31:0]     r_fetchPc;
  logic [31:0]     r_qData [DEPTH];
  logic [31:0]     r_qPc   [DEPTH];
  logic [31:0]     r_tagPc [DEPTH];
  logic [c_AW-1:0] r_head;
  logic [c_AW-1:0] r_tail;
  logic [c_AW-1:0] r_tagWr;
  logic [c_AW-1:0] r_tagRd;
  logic [c_CW-1:0] r_count;
  logic [c_OW-1:0] r_outstanding;
  logic [c_OW-1:0] r_drop;

  logic        w_qEmpty;
  logic        w_memReq;
  logic        w_grant;
  logic        w_respOk;
  logic        w_bypass;
  logic        w_push;
  logic        w_qPop;
  logic        w_headValid;
  logic [31:0] w_respPc;
  logic [31:0] w_instr;
  logic [31:0] w_instrPc;

  assign w_qEmpty = (r_count == '0);
  // Outstanding requests reserve queue slots, so a full queue can never overflow.
  assign w_memReq = reset && !branch && (r_outstanding < c_OW'(MAX_OUT)) &&
                    ((32'(r_count) + 32'(r_outstanding)) < DEPTH);
  assign w_grant  = w_memReq && mem_gnt;
  assign w_respOk = mem_rvalid && !branch && (r_drop == '0);
  assign w_respPc = r_tagPc[r_tagRd];

`ifdef FETCHQ_BYPASS_EN
  assign w_bypass = w_qEmpty && w_respOk;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_headValid = !w_qEmpty || w_bypass;
  assign w_push      = w_respOk && !(w_bypass && pop);
  assign w_qPop      = pop && !branch && !w_qEmpty;

  always_comb begin
    w_instr   = '0;
    w_instrPc = '0;
    if (w_bypass) begin
      w_instr   = mem_rdata;
      w_instrPc = w_respPc;
    end else if (!w_qEmpty) begin
      w_instr   = r_qData[r_head];
      w_instrPc = r_qPc[r_head];
    end
  end

  assign mem_req     = w_memReq;
  assign mem_addr    = r_fetchPc;
  assign instr_valid = w_headValid;
  assign instr       = w_instr;
  assign instr_pc    = w_instrPc;
  assign encode      = w_headValid && (w_instr[1:0] != 2'b11);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetchPc     <= RESET_PC;
      r_head        <= '0;
      r_tail        <= '0;
      r_tagWr       <= '0;
      r_tagRd       <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      if (branch) begin
        r_fetchPc <= {branch_target[31:2], 2'b00};
        r_head    <= '0;
        r_tail    <= '0;
        r_count   <= '0;
        // Everything still in flight belongs to the old path.
        r_drop    <= r_outstanding - c_OW'(mem_rvalid);
      end else begin
        if (w_grant) r_fetchPc <= r_fetchPc + 32'd4;
        if (w_push)  r_tail    <= r_tail + 1'b1;
        if (w_qPop)  r_head    <= r_head + 1'b1;
        r_count <= r_count + c_CW'(w_push) - c_CW'(w_qPop);
        if (mem_rvalid && (r_drop != '0)) r_drop <= r_drop - 1'b1;
      end
      r_outstanding <= r_outstanding + c_OW'(w_grant) - c_OW'(mem_rvalid);
      if (w_grant)    r_tagWr <= r_tagWr + 1'b1;
      if (mem_rvalid) r_tagRd <= r_tagRd + 1'b1;
    end
  end

  // Storage arrays need no reset; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qData[r_tail] <= mem_rdata;
      r_qPc[r_tail]   <= w_respPc;
    end
    if (w_grant) r_tagPc[r_tagWr] <= r_fetchPc;
  end

endmodule
`default_nettype wire
